// File: rtl/wb_periph_fabric.sv
// Wishbone single-master to N-slave peripheral fabric: registered decode, one-hot
// slave strobes, registered response return, bus timeout and latched interrupt aggregation.
module wb_periph_fabric #(
    parameter int unsigned SEL_W  = 1,
    parameter int unsigned NSLV   = 2,
    parameter int unsigned AW     = 3,
    parameter int unsigned DW     = 8,
    parameter int unsigned TO_CYC = 255
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   m_cyc_i,
    input  logic                   m_stb_i,
    input  logic                   m_we_i,
    input  logic [SEL_W+AW-1:0]    m_adr_i,
    input  logic [DW-1:0]          m_dat_i,
    output logic [DW-1:0]          m_dat_o,
    output logic                   m_ack_o,
    output logic                   m_err_o,
    output logic                   m_int_o,
    output logic                   s_cyc_o,
    output logic [NSLV-1:0]        s_stb_o,
    output logic [AW-1:0]          s_adr_o,
    output logic                   s_we_o,
    output logic [DW-1:0]          s_dat_o,
    input  logic [NSLV*DW-1:0]     s_dat_i,
    input  logic [NSLV-1:0]        s_ack_i,
    input  logic [NSLV-1:0]        s_int_i,
    input  logic [NSLV-1:0]        int_mask_i,
    input  logic [NSLV-1:0]        int_clr_i,
    output logic [NSLV-1:0]        int_pend_o
);

    localparam int unsigned CNT_RAW = $clog2(TO_CYC + 1);
    localparam int unsigned CNT_W   = (CNT_RAW < 1) ? 1 : CNT_RAW;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TO_CYC == 0) ? 0 : TO_CYC - 1);

    typedef enum logic [2:0] {IDLE, ACCESS, RESP, ERR, GUARD} state_e;

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               s_cyc_q, s_cyc_d;
    logic [NSLV-1:0]    s_stb_q, s_stb_d;
    logic [AW-1:0]      s_adr_q, s_adr_d;
    logic               s_we_q, s_we_d;
    logic [DW-1:0]      s_dat_q, s_dat_d;
    logic [DW-1:0]      m_dat_q, m_dat_d;
    logic               m_ack_q, m_ack_d;
    logic               m_err_q, m_err_d;
    logic               m_int_q, m_int_d;
    logic [NSLV-1:0]    pend_q, pend_d;
    logic [NSLV-1:0]    hist_q, hist_d;

    logic               ack_hit;
    logic [DW-1:0]      rdat_sel;
    logic [NSLV-1:0]    stb_dec;

    // Next-state, response capture and registered output decode
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        s_adr_d  = s_adr_q;
        s_we_d   = s_we_q;
        s_dat_d  = s_dat_q;
        m_dat_d  = m_dat_q;
        rdat_sel = '0;
        stb_dec  = '0;

        // s_stb_q is one-hot during ACCESS, so it doubles as the return-mux select
        ack_hit = |(s_ack_i & s_stb_q);
        for (int unsigned k = 0; k < NSLV; k++) begin
            if (s_stb_q[k]) rdat_sel = s_dat_i[k*DW +: DW];
        end

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (m_cyc_i && m_stb_i) begin
                    idx_d   = m_adr_i[SEL_W+AW-1:AW];
                    s_adr_d = m_adr_i[AW-1:0];
                    s_we_d  = m_we_i;
                    s_dat_d = m_dat_i;
                    state_d = (32'(idx_d) < NSLV) ? ACCESS : ERR;
                end
            end
            ACCESS: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (ack_hit) begin
                    m_dat_d = rdat_sel;
                    state_d = RESP;
                end else if (!m_cyc_i) begin
                    state_d = IDLE;
                end else if ((TO_CYC != 0) && (cnt_q == TO_LAST)) begin
                    state_d = ERR;
                end
            end
            RESP:    state_d = GUARD;
            ERR:     state_d = GUARD;
            GUARD:   state_d = IDLE;
            default: state_d = IDLE;
        endcase

        for (int unsigned k = 0; k < NSLV; k++) begin
            stb_dec[k] = (idx_d == SEL_W'(k));
        end

        s_cyc_d = (state_d == ACCESS);
        s_stb_d = (state_d == ACCESS) ? stb_dec : '0;
        m_ack_d = (state_d == RESP);
        m_err_d = (state_d == ERR);

        // Set beats clear when an edge and a clear land together
        hist_d  = s_int_i;
        pend_d  = (pend_q & ~int_clr_i) | (s_int_i & ~hist_q);
        m_int_d = |(pend_q & ~int_mask_i);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            s_cyc_q <= 1'b0;
            s_stb_q <= '0;
            s_adr_q <= '0;
            s_we_q  <= 1'b0;
            s_dat_q <= '0;
            m_dat_q <= '0;
            m_ack_q <= 1'b0;
            m_err_q <= 1'b0;
            m_int_q <= 1'b0;
            pend_q  <= '0;
            hist_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            s_cyc_q <= s_cyc_d;
            s_stb_q <= s_stb_d;
            s_adr_q <= s_adr_d;
            s_we_q  <= s_we_d;
            s_dat_q <= s_dat_d;
            m_dat_q <= m_dat_d;
            m_ack_q <= m_ack_d;
            m_err_q <= m_err_d;
            m_int_q <= m_int_d;
            pend_q  <= pend_d;
            hist_q  <= hist_d;
        end
    end

    assign m_dat_o    = m_dat_q;
    assign m_ack_o    = m_ack_q;
    assign m_err_o    = m_err_q;
    assign m_int_o    = m_int_q;
    assign s_cyc_o    = s_cyc_q;
    assign s_stb_o    = s_stb_q;
    assign s_adr_o    = s_adr_q;
    assign s_we_o     = s_we_q;
    assign s_dat_o    = s_dat_q;
    assign int_pend_o = pend_q;

endmodule

// File: doc/wb_periph_fabric.md
Name: wb_periph_fabric

Overview:
- Parametrised Wishbone single-master to N-slave peripheral fabric, for chip tops that connect the state controller to several communication cores (SPI, I2C, later additions).
- Replaces ad-hoc select-driven return muxing with three functions:
  - registered address decode
  - per-slave strobe generation
  - registered response return
- Adds features the fixed two-slave top lacks:
  - bus timeout with error termination
  - master abort handling
  - latched, maskable interrupt aggregation

Parameters:
- SEL_W, 1: number of upper address bits that select a slave.
- NSLV, 2: number of attached slaves. Legal range is 1 to 2**SEL_W.
- AW, 3: slave-local address width.
- DW, 8: data width.
- TO_CYC, 255: number of cycles in ACCESS without an ack before an error termination. A value of 0 disables the timeout.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  asynchronous active-low reset
- m_cyc_i  in  1  master cycle
- m_stb_i  in  1  master strobe
- m_we_i  in  1  master write enable
- m_adr_i  in  SEL_W+AW  master address; bits [SEL_W+AW-1:AW] carry the slave index
- m_dat_i  in  DW  master write data
- m_dat_o  out  DW  registered read data
- m_ack_o  out  1  normal termination, one-cycle pulse
- m_err_o  out  1  error termination, one-cycle pulse
- m_int_o  out  1  aggregated interrupt
- s_cyc_o  out  1  slave cycle, shared by all slaves
- s_stb_o  out  NSLV  one-hot slave strobes
- s_adr_o  out  AW  slave-local address
- s_we_o  out  1  slave write enable
- s_dat_o  out  DW  slave write data
- s_dat_i  in  NSLV*DW  packed slave read data; slave k occupies [k*DW +: DW]
- s_ack_i  in  NSLV  slave acks
- s_int_i  in  NSLV  slave interrupt levels
- int_mask_i  in  NSLV  mask per slave; 1 disables that interrupt
- int_clr_i  in  NSLV  pending-clear pulses
- int_pend_o  out  NSLV  latched pending interrupts

Behaviour:
- Reset (rst_i=0, asynchronous) clears all of the following to 0:
  - all outputs
  - FSM state (forced to IDLE)
  - timeout counter
  - pending register
  - interrupt edge history
- The FSM has five states: IDLE, ACCESS, RESP, ERR, GUARD.
- IDLE:
  - On m_cyc_i & m_stb_i, latch the slave index, s_adr_o, s_we_o and s_dat_o from the master.
  - If index < NSLV, go to ACCESS.
  - Otherwise (unmapped index), go to ERR.
- ACCESS:
  - s_cyc_o=1 and s_stb_o[index]=1; all other strobes are 0.
  - The timeout counter increments every cycle.
  - If s_ack_i[index]=1: capture s_dat_i slice [index] into m_dat_o, go to RESP.
  - Else if m_cyc_i=0 (master abort): go to IDLE, with no ack and no err.
  - Else if TO_CYC!=0 and the counter has reached TO_CYC-1: go to ERR.
  - Priority is ack, then abort, then timeout.
  - Acks from non-selected slaves are ignored.
- RESP: m_ack_o=1 for one cycle, s_cyc_o/s_stb_o=0, then go to GUARD.
- ERR: m_err_o=1 for one cycle, m_dat_o unchanged, then go to GUARD.
- GUARD: one idle cycle that blocks re-acceptance of the still-high master strobe. Go to IDLE.
- Latency: request accepted in cycle 0 → s_stb_o high from cycle 1. A slave ack sampled in cycle k → m_ack_o in cycle k+1.
- The counter clears on entry to ACCESS. Width is clog2(TO_CYC+1), minimum 1.
- m_dat_o holds its value until the next successful read or write ack. Write acks also load the slice value.
- Interrupts:
  - s_int_i is registered every cycle to detect rising edges.
  - A rising edge on bit k sets pend[k].
  - An int_clr_i[k] pulse clears pend[k].
  - If an edge and a clear arrive in the same cycle, set wins.
  - int_pend_o = pend.
  - m_int_o, registered, = |(pend & ~int_mask_i).
  - Masking does not prevent latching.
- Reset mid-transfer drops every strobe immediately. No ack or err is produced after reset release.

Test Plan:
- Read, NSLV=2: master reads adr=0b0_010 and slave0 acks 3 cycles after its strobe with 0xA5 → s_stb_o=01 and s_adr_o=010. m_ack_o pulses exactly 1 cycle, 1 cycle after the slave ack, with m_dat_o=0xA5. A second transfer is accepted no earlier than 2 cycles after the ack.
- Write to slave1: master writes 0x3C to adr=0b1_101 → s_stb_o=10, s_we_o=1, s_dat_o=0x3C, s_adr_o=101. Ack returned. A spurious s_ack_i[0] during the access is ignored.
- Unmapped and timeout: with SEL_W=2 and NSLV=3, an access to index 3 gives m_err_o 1 cycle after acceptance and no s_stb_o. With TO_CYC=4 and a silent slave, m_err_o arrives after exactly 4 ACCESS cycles and the strobe drops.
- Abort: m_cyc_i drops 2 cycles into ACCESS → s_stb_o=0 the next cycle, with neither m_ack_o nor m_err_o.
- Interrupts:
  - A rising s_int_i[1] with int_mask_i=00 gives int_pend_o=10, and m_int_o=1 one cycle later.
  - Setting mask=10 drives m_int_o to 0 while pend stays set.
  - int_clr_i=10 in the same cycle as a new s_int_i[1] edge leaves pend[1]=1.
- Reset: rst_i asserted low during ACCESS → all outputs are 0 immediately, and no ack follows after release.
